mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage access controller of the pipelined MIPS32 core, between the EX/MEM pipeline register and the word-organised data memory; also owns the MEM/WB register.
- Converts byte, halfword and word loads/stores (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses.
- Sub-word stores use a 2-cycle read-modify-write (RMW) with a stall to the hazard unit.
- Load results are lane-extracted, extended and registered into MEM/WB.

Parameters:
- ADDR_W, 10, word-index width of the data memory (1024 words).
- BIG_ENDIAN, 1, 1: byte offset 0 selects bits [31:24]; 0: selects bits [7:0].

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ex_rd  in  1  load request from EX/MEM.
- ex_wr  in  1  store request from EX/MEM (ex_rd and ex_wr both 1 is treated as a load).
- ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- ex_unsigned  in  1  zero-extend the load (LBU/LHU).
- ex_addr  in  32  byte address (ALU result).
- ex_wdata  in  32  store data (rt value, right-aligned).
- ex_regwrite  in  1  instruction writes the register file.
- ex_dest  in  5  destination register.
- dm_rd  out  1  data memory read enable.
- dm_wr  out  1  data memory write enable.
- dm_addr  out  32  word index = {zeros, ex_addr[ADDR_W+1:2]}.
- dm_wdata  out  32  word written to memory.
- dm_rdata  in  32  asynchronous read data from memory.
- stall  out  1  hold IF/ID/EX and EX/MEM.
- wb_regwrite  out  1  MEM/WB register-write enable.
- wb_dest  out  5  MEM/WB destination.
- wb_data  out  32  load data, or ex_addr passthrough for ALU instructions.
- misalign  out  1  registered one-cycle alignment-fault pulse.

Behaviour:
- Reset: clk and rst as stated; rst is synchronous and active-high. All registered outputs reset to 0 (wb_regwrite, wb_dest, wb_data, misalign). FSM goes to IDLE and the merge register clears.
- dm_rd, dm_wr and stall are combinational from state and inputs. All three are 0 in reset and while rst is high.
- Alignment: a half access is misaligned when addr[0]=1. A word access is misaligned when addr[1:0]!=0.
- Misaligned access: dm_rd=dm_wr=0, no stall, next cycle misalign=1 and wb_regwrite=0.
- FSM states: IDLE, RMW_WR.
- IDLE, no access: ex_addr, ex_regwrite and ex_dest are registered into MEM/WB. Latency is 1 cycle.
- IDLE, load: dm_rd=1. Extract the lane selected by addr[1:0] and BIG_ENDIAN. Sign- or zero-extend per ex_unsigned; a word load is unmodified. Register the result into wb_data; wb_regwrite=ex_regwrite. Latency is 1 cycle, with no stall.
- IDLE, word store: dm_wr=1, dm_wdata=ex_wdata. Single cycle. Next cycle wb_regwrite=0.
- IDLE, aligned sub-word store: dm_rd=1, stall=1, capture dm_rdata into merge_q, go to RMW_WR. MEM/WB receives a bubble (wb_regwrite=0).
- RMW_WR: dm_wr=1, stall=0. dm_wdata = merge_q with the addressed byte/half lane replaced by ex_wdata[7:0] or ex_wdata[15:0]. Return to IDLE; next cycle wb_regwrite=0.
- Upstream holds all ex_* inputs stable while stall=1. The unit relies on that and does not re-latch ex_addr.
- rst in RMW_WR: no write occurs (dm_wr is gated by rst), state goes to IDLE, no stall.
- Addresses beyond 2^(ADDR_W+2) bytes wrap modulo memory size, since upper bits are dropped. No fault is raised.
- Only one memory operation per cycle; dm_rd and dm_wr are never both 1.

Decomposition:
- Package mips_mem_pkg holds: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and function lane_merge(word, data, offset, size).
- One natural sub-module: load_align (combinational lane extract and extend), reused by any future cache path.

Test Plan:
- Reset: memory word 0 = 0x11223344, LW addr 0 with ex_regwrite=1, ex_dest=8 -> next cycle wb_data=0x11223344, wb_regwrite=1, wb_dest=8, stall never asserted.
- Byte loads, BIG_ENDIAN=1, word 0x80FF7F01 at addr 0x10: LB 0x11 -> 0xFFFFFFFF; LBU 0x11 -> 0x000000FF; LB 0x12 -> 0x0000007F; LH 0x10 -> 0xFFFF80FF.
- SB 0xAB to addr 0x21, word = 0x11223344 -> cycle 1: dm_rd=1, stall=1; cycle 2: dm_wr=1, dm_wdata=0x11AB3344, stall=0; readback LW = 0x11AB3344.
- SH 0xBEEF to addr 0x22 on word 0 -> after RMW the word = 0x0000BEEF. Back-to-back SB then LW to the same word returns the merged value.
- LH at 0x03 or SW at 0x06 -> no dm_rd/dm_wr, misalign pulses exactly 1 cycle, wb_regwrite=0, memory unchanged.
- rst asserted in the RMW_WR cycle of an SB -> dm_wr=0, memory unchanged, all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS32 MEM-stage access path.
// Contents: access-size encodings, the access-unit FSM state type, and
// lane_merge(), which drops a byte or halfword into a word. lane_merge takes
// a little-endian lane number (0 = bits [7:0]); callers apply endianness.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also treated as word

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } mem_state_e;

    // Replace the addressed byte/half lane of word with the low bits of data.
    // For halves only lane[1] matters: 0 -> bits [15:0], 1 -> bits [31:16].
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [1:0]  lane,
        input logic [1:0]  size
    );
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{lane, 3'b000} +: 8]         = data[7:0];
            SZ_HALF: res[{lane[1], 4'b0000} +: 16]    = data[15:0];
            default: res                              = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational lane extraction and sign/zero extension of a
// loaded word.
// Ports:
//   rdata_i       raw 32-bit word from memory
//   offset_i      byte offset within the word (addr[1:0])
//   size_i        access size (SZ_BYTE / SZ_HALF / word)
//   is_unsigned_i 1 = zero-extend, 0 = sign-extend (ignored for words)
//   data_o        right-aligned, extended result
module load_align
    import mips_mem_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    output logic [31:0] data_o
);

    logic [1:0]  lane_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Big-endian offset 0 is the most significant lane, so invert the offset.
    assign lane_s = (BIG_ENDIAN != 0) ? ~offset_i : offset_i;
    assign byte_s = rdata_i[{lane_s, 3'b000} +: 8];
    assign half_s = rdata_i[{lane_s[1], 4'b0000} +: 16];

    // Extend the selected lane to 32 bits.
    always_comb begin
        data_o = rdata_i;
        case (size_i)
            SZ_BYTE: data_o = is_unsigned_i ? {24'h000000, byte_s}
                                            : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: data_o = is_unsigned_i ? {16'h0000, half_s}
                                            : {{16{half_s[15]}}, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller between EX/MEM and a word-organised
// data memory; owns the MEM/WB register. Sub-word stores use a two-cycle
// read-modify-write, stalling upstream during the read cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_rd/ex_wr         load/store request (both set = load)
//   ex_size/ex_unsigned access size and load extension mode
//   ex_addr/ex_wdata    byte address, right-aligned store data
//   ex_regwrite/ex_dest register-file write intent and target
//   dm_rd/dm_wr/dm_addr/dm_wdata/dm_rdata  data memory interface (async read)
//   stall               hold IF/ID/EX and EX/MEM
//   wb_regwrite/wb_dest/wb_data  MEM/WB register
//   misalign            registered one-cycle alignment-fault pulse
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_rd,
    input  logic        ex_wr,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_dest,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        wb_regwrite,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        misalign
);

    mem_state_e  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;

    logic        rd_s, wr_s, stall_s;
    logic        is_half_s, is_word_s, misalign_s;
    logic [1:0]  lane_s;
    logic [31:0] load_data_s;

    assign dm_addr   = {{(32 - ADDR_W){1'b0}}, ex_addr[ADDR_W+1:2]};
    assign is_half_s = (ex_size == SZ_HALF);
    assign is_word_s = (ex_size != SZ_BYTE) && (ex_size != SZ_HALF);
    assign lane_s    = (BIG_ENDIAN != 0) ? ~ex_addr[1:0] : ex_addr[1:0];

    // Fault only matters when an access is actually requested.
    assign misalign_s = (ex_rd || ex_wr) &&
                        ((is_half_s && ex_addr[0]) ||
                         (is_word_s && (ex_addr[1:0] != 2'b00)));

    load_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_align (
        .rdata_i       (dm_rdata),
        .offset_i      (ex_addr[1:0]),
        .size_i        (ex_size),
        .is_unsigned_i (ex_unsigned),
        .data_o        (load_data_s)
    );

    // Next-state, memory strobes and MEM/WB next values.
    always_comb begin
        state_d       = state_q;
        merge_d       = merge_q;
        rd_s          = 1'b0;
        wr_s          = 1'b0;
        stall_s       = 1'b0;
        dm_wdata      = ex_wdata;
        wb_regwrite_d = 1'b0;
        wb_dest_d     = ex_dest;
        wb_data_d     = ex_addr;
        misalign_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (misalign_s) begin
                    misalign_d = 1'b1;
                end else if (ex_rd) begin
                    rd_s          = 1'b1;
                    wb_data_d     = load_data_s;
                    wb_regwrite_d = ex_regwrite;
                end else if (ex_wr) begin
                    if (is_word_s) begin
                        wr_s = 1'b1;
                    end else begin
                        // First half of RMW: fetch the word being patched.
                        rd_s    = 1'b1;
                        stall_s = 1'b1;
                        merge_d = dm_rdata;
                        state_d = ST_RMW_WR;
                    end
                end else begin
                    wb_regwrite_d = ex_regwrite;
                end
            end
            ST_RMW_WR: begin
                // ex_* are held by upstream across the stall, so ex_addr
                // still names the lane to patch.
                wr_s     = 1'b1;
                dm_wdata = lane_merge(merge_q, ex_wdata, lane_s, ex_size);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset suppresses every memory strobe, including a pending RMW write.
    assign dm_rd = rd_s    & ~rst;
    assign dm_wr = wr_s    & ~rst;
    assign stall = stall_s & ~rst;

    // FSM, merge buffer and MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            merge_q       <= 32'h0000_0000;
            wb_regwrite_q <= 1'b0;
            wb_dest_q     <= 5'd0;
            wb_data_q     <= 32'h0000_0000;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            merge_q       <= merge_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_dest_q     <= wb_dest_d;
            wb_data_q     <= wb_data_d;
            misalign_q    <= misalign_d;
        end
    end

    assign wb_regwrite = wb_regwrite_q;
    assign wb_dest     = wb_dest_q;
    assign wb_data     = wb_data_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1024-word memory.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        ex_rd, ex_wr, ex_unsigned, ex_regwrite;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_dest;
    logic        dm_rd, dm_wr, stall, wb_regwrite, misalign;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, wb_data;
    logic [4:0]  wb_dest;

    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.ADDR_W(10), .BIG_ENDIAN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_rd       (ex_rd),
        .ex_wr       (ex_wr),
        .ex_size     (ex_size),
        .ex_unsigned (ex_unsigned),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .ex_regwrite (ex_regwrite),
        .ex_dest     (ex_dest),
        .dm_rd       (dm_rd),
        .dm_wr       (dm_wr),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .stall       (stall),
        .wb_regwrite (wb_regwrite),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .misalign    (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign dm_rdata = mem[dm_addr[9:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (dm_wr) mem[dm_addr[9:0]] <= dm_wdata;
    end

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wdata;
        logic        regw;
        logic [4:0]  dest;
        logic        e_rd, e_wr, e_rw, e_mis;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic regw,
                         input logic [4:0] dest);
        ex_rd = rd; ex_wr = wr; ex_size = sz; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wdata; ex_regwrite = regw; ex_dest = dest;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic regw, input logic [4:0] dest,
                           input logic e_rd, input logic e_wr, input logic e_rw,
                           input logic e_mis, input logic [31:0] e_data);
        vecs[i].rd = rd; vecs[i].wr = wr; vecs[i].sz = sz; vecs[i].uns = uns;
        vecs[i].addr = addr; vecs[i].wdata = wdata; vecs[i].regw = regw;
        vecs[i].dest = dest; vecs[i].e_rd = e_rd; vecs[i].e_wr = e_wr;
        vecs[i].e_rw = e_rw; vecs[i].e_mis = e_mis; vecs[i].e_data = e_data;
    endtask

    initial begin
        pl_en = 1'b0; pl_idx = 10'd0; pl_data = 32'h0;
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 5'd8);

        //             rd    wr    sz     uns   addr          wdata         rw    dest   erd   ewr   erw   emis  edata
        set_vec( 0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 5'd8,  1'b1, 1'b0, 1'b1, 1'b0, 32'h1122_3344);
        set_vec( 1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        set_vec( 2, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00FF);
        set_vec( 3, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,        1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_007F);
        set_vec( 4, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_80FF);
        set_vec( 5, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_7F01);
        set_vec( 6, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        set_vec( 7, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF80);
        set_vec( 8, 1'b0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,        1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        set_vec( 9, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0,        1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        set_vec(10, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0,        1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80FF_7F01);
        set_vec(11, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 5'd17, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1122_3344);
        set_vec(12, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0011, 32'h5555_5555, 1'b1, 5'd18, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00FF);
        set_vec(13, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,        1'b1, 5'd19, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        set_vec(14, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 5'd20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1122_3344);
        set_vec(15, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'hAAAA_AAAA, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        set_vec(16, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        set_vec(17, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,        1'b1, 5'd21, 1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
        set_vec(18, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        1'b0, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state, with a load request present on the inputs.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("rst_wb_dest", {27'd0, wb_dest}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_dm_rd", {31'd0, dm_rd}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        preload(10'd0, 32'h1122_3344);
        preload(10'd1, 32'h9988_7766);
        preload(10'd4, 32'h80FF_7F01);
        preload(10'd8, 32'h1122_3344);
        preload(10'd9, 32'h5566_7788);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle vectors.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                  vecs[i].wdata, vecs[i].regw, vecs[i].dest);
            #1;
            chk($sformatf("v%0d_dm_rd", i), {31'd0, dm_rd}, {31'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_dm_wr", i), {31'd0, dm_wr}, {31'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
            chk($sformatf("v%0d_dm_addr", i), dm_addr, {22'd0, vecs[i].addr[11:2]});
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_regwrite", i), {31'd0, wb_regwrite}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vecs[i].e_mis});
            if (vecs[i].e_rw) begin
                chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
                chk($sformatf("v%0d_wb_dest", i), {27'd0, wb_dest}, {27'd0, vecs[i].dest});
            end
        end
        chk("mis_store_mem_unchanged", mem[1], 32'h9988_7766);

        // SB 0xAB to 0x21, then back-to-back LW of the same word.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56AB, 1'b0, 5'd0);
        #1;
        chk("sb_c1_dm_rd", {31'd0, dm_rd}, 32'd1);
        chk("sb_c1_dm_wr", {31'd0, dm_wr}, 32'd0);
        chk("sb_c1_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("sb_c1_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        @(negedge clk); #1;
        chk("sb_c2_dm_wr", {31'd0, dm_wr}, 32'd1);
        chk("sb_c2_dm_rd", {31'd0, dm_rd}, 32'd0);
        chk("sb_c2_stall", {31'd0, stall}, 32'd0);
        chk("sb_c2_dm_wdata", dm_wdata, 32'h11AB_3344);
        @(posedge clk); #1;
        chk("sb_c2_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("sb_mem", mem[8], 32'h11AB_3344);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 5'd5);
        #1;
        chk("sb_lw_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("sb_lw_data", wb_data, 32'h11AB_3344);
        chk("sb_lw_regwrite", {31'd0, wb_regwrite}, 32'd1);

        // SH 0xBEEF to 0x22 on a zero word.
        preload(10'd8, 32'h0000_0000);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hDEAD_BEEF, 1'b0, 5'd0);
        #1;
        chk("sh_c1_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk); #1;
        chk("sh_c2_dm_wr", {31'd0, dm_wr}, 32'd1);
        chk("sh_c2_dm_wdata", dm_wdata, 32'h0000_BEEF);
        @(posedge clk); #1;
        chk("sh_mem", mem[8], 32'h0000_BEEF);

        // Reset during the RMW write cycle of an SB.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h24, 32'h0000_0012, 1'b1, 5'd7);
        #1;
        chk("rrmw_c1_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("rrmw_c1_wb_dest", {27'd0, wb_dest}, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rrmw_dm_wr", {31'd0, dm_wr}, 32'd0);
        chk("rrmw_dm_rd", {31'd0, dm_rd}, 32'd0);
        chk("rrmw_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("rrmw_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("rrmw_wb_dest", {27'd0, wb_dest}, 32'd0);
        chk("rrmw_wb_data", wb_data, 32'd0);
        chk("rrmw_misalign", {31'd0, misalign}, 32'd0);
        chk("rrmw_mem", mem[9], 32'h5566_7788);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 1'b0, 5'd0);
        #1;
        chk("rrmw_idle_dm_wr", {31'd0, dm_wr}, 32'd0);
        chk("rrmw_idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("rrmw_mem_after", mem[9], 32'h5566_7788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
